// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
package loader_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        COLLECT,
        WRITE,
        GAP,
        VERIFY,
        DONE,
        ERROR
    } loader_state_t;

    // One beat of the incoming byte stream.
    typedef struct packed {
        logic [BYTE_W-1:0] data;
        logic              last;
    } byte_beat_t;

    // Place a byte in its big-endian lane; lane 0 is bits [31:24].
    function automatic logic [WORD_W-1:0] lane_place(input logic [BYTE_W-1:0] b,
                                                     input logic [IDX_W-1:0]  idx);
        logic [WORD_W-1:0] w;
        w = '0;
        case (idx)
            2'd0:    w[31:24] = b;
            2'd1:    w[23:16] = b;
            2'd2:    w[15:8]  = b;
            default: w[7:0]   = b;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream and RAM handshake bundle between the loader and its environment.
interface prog_loader_if #(
    parameter int unsigned ADDR_W = 16
) ();

    logic              s_valid;
    logic              s_ready;
    logic [7:0]        s_data;
    logic              s_last;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_done;
    logic              mem_cs;
    logic              mem_we;
    logic              mem_oe;

    modport master (
        input  s_valid, s_data, s_last, mem_rdata, mem_done,
        output s_ready, mem_addr, mem_wdata, mem_cs, mem_we, mem_oe
    );

    modport slave (
        output s_valid, s_data, s_last, mem_rdata, mem_done,
        input  s_ready, mem_addr, mem_wdata, mem_cs, mem_we, mem_oe
    );

endinterface

// File: rtl/byte_packer.sv
// Assembles big-endian bytes into 32-bit words; a last byte zero-pads the word.
module byte_packer
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              accept,
    input  byte_beat_t        beat,
    output logic [WORD_W-1:0] word_c,
    output logic              word_ready_c
);

    logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;

    // Lower lanes are always zero in shreg, so OR-ing the new lane also pads.
    always_comb begin
        byte_idx_d   = byte_idx_q;
        shreg_d      = shreg_q;
        word_c       = shreg_q | lane_place(beat.data, byte_idx_q);
        word_ready_c = accept && ((byte_idx_q == IDX_W'(BYTES_PER_WORD - 1)) || beat.last);
        if (accept) begin
            if (word_ready_c) begin
                byte_idx_d = '0;
                shreg_d    = '0;
            end else begin
                byte_idx_d = byte_idx_q + IDX_W'(1);
                shreg_d    = word_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx_q <= '0;
            shreg_q    <= '0;
        end else begin
            byte_idx_q <= byte_idx_d;
            shreg_q    <= shreg_d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Loads a byte-stream image into RAM word by word, reads it back and
// checks it against the running XOR checksum before releasing the core.
module prog_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned MAX_WORDS = 1024,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    prog_loader_if.master     bus,
    output logic [ADDR_W-1:0] word_count,
    output logic              done,
    output logic              error
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    loader_state_t     state_q, state_d;
    logic              s_ready_q, s_ready_d;
    logic              cs_q, cs_d;
    logic              we_q, we_d;
    logic              oe_q, oe_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] word_count_q, word_count_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [WORD_W-1:0] csum_q, csum_d;
    logic [WORD_W-1:0] rd_csum_q, rd_csum_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              last_seen_q, last_seen_d;

    logic              accept;
    logic              overflow;
    logic              timeout;
    logic [WORD_W-1:0] word_c;
    logic              word_ready_c;
    byte_beat_t        beat;

    // s_ready_q is only ever high while in COLLECT.
    assign accept   = bus.s_valid && s_ready_q;
    assign overflow = (word_count_q == ADDR_W'(MAX_WORDS));
    assign timeout  = cs_q && !bus.mem_done && (tmo_q == TMO_W'(TIMEOUT - 1));
    assign beat     = '{data: bus.s_data, last: bus.s_last};

    byte_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .accept       (accept && !overflow),
        .beat         (beat),
        .word_c       (word_c),
        .word_ready_c (word_ready_c)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        word_count_d = word_count_q;
        csum_d       = csum_q;
        rd_csum_d    = rd_csum_q;
        last_seen_d  = last_seen_q;
        tmo_d        = (cs_q && !bus.mem_done) ? tmo_q + TMO_W'(1) : '0;

        case (state_q)
            COLLECT: begin
                if (accept) begin
                    if (bus.s_last) last_seen_d = 1'b1;
                    if (overflow) begin
                        state_d = ERROR;
                    end else if (word_ready_c) begin
                        state_d = WRITE;
                        addr_d  = word_count_q;
                        wdata_d = word_c;
                    end
                end
            end
            WRITE: begin
                if (timeout) begin
                    state_d = ERROR;
                end else if (bus.mem_done) begin
                    csum_d       = csum_q ^ wdata_q;
                    word_count_d = word_count_q + ADDR_W'(1);
                    // Read-back starts at word 0 once the final word is in.
                    if (last_seen_q) addr_d = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = last_seen_q ? VERIFY : COLLECT;
            end
            VERIFY: begin
                if (timeout) begin
                    state_d = ERROR;
                end else if (bus.mem_done) begin
                    rd_csum_d = rd_csum_q ^ bus.mem_rdata;
                    if (addr_q == word_count_q - ADDR_W'(1)) begin
                        state_d = (rd_csum_d == csum_q) ? DONE : ERROR;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = GAP;
                    end
                end
            end
            DONE:    state_d = DONE;
            ERROR:   state_d = ERROR;
            default: state_d = ERROR;
        endcase

        // Bus and status outputs follow the next state so they flop with it.
        s_ready_d = (state_d == COLLECT);
        cs_d      = (state_d == WRITE) || (state_d == VERIFY);
        we_d      = (state_d == WRITE);
        oe_d      = (state_d == VERIFY);
        done_d    = (state_d == DONE);
        error_d   = (state_d == ERROR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= COLLECT;
            s_ready_q    <= 1'b0;
            cs_q         <= 1'b0;
            we_q         <= 1'b0;
            oe_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            word_count_q <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            csum_q       <= '0;
            rd_csum_q    <= '0;
            tmo_q        <= '0;
            last_seen_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_ready_q    <= s_ready_d;
            cs_q         <= cs_d;
            we_q         <= we_d;
            oe_q         <= oe_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            word_count_q <= word_count_d;
            done_q       <= done_d;
            error_q      <= error_d;
            csum_q       <= csum_d;
            rd_csum_q    <= rd_csum_d;
            tmo_q        <= tmo_d;
            last_seen_q  <= last_seen_d;
        end
    end

    assign bus.s_ready   = s_ready_q;
    assign bus.mem_cs    = cs_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_oe    = oe_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign word_count    = word_count_q;
    assign done          = done_q;
    assign error         = error_q;

endmodule
